// File: rtl/mul_pkg.sv
// Shared definitions for the multiply scheduler: FSM encoding, the
// watchdog limit and the width of the BCD result bus.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Extra RUN cycles allowed beyond the operand width before the core
    // is declared stuck.
    localparam int TIMEOUT_EXTRA = 4;

    // Digits needed for a 2n-bit binary value, four bits per digit.
    function automatic int bcd_width(input int n);
        return ((2 * n) / 3 + 1) * 4;
    endfunction

    // Number of RUN cycles without mul_finish that triggers a timeout.
    function automatic int timeout_cycles(input int n);
        return n + TIMEOUT_EXTRA;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after
// last+1, wrapping around, and returns it one-hot and as an index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any_grant
);

    int            cand;
    logic [IW-1:0] cand_idx;

    // Walk upward from last+1 and take the first requester found.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand     = (int'(last) + i) % NREQ;
            cand_idx = IW'(cand);
            if (!any_grant && req[cand_idx]) begin
                any_grant       = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mul_scheduler.sv
// Shares one external multiplier core among NREQ requesters.
// Handshakes: a request transfers in the cycle req_valid[k] and
// req_ready[k] are both high (req_ready is a one-cycle, one-hot pulse
// raised only in IDLE); a response transfers in the cycle rsp_valid and
// rsp_ready are both high, and rsp_id/rsp_bin/rsp_bcd hold steady while
// rsp_valid waits for rsp_ready.
module mul_scheduler
    import mul_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int BW   = bcd_width(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]     rsp_id,
    output logic [2*N-1:0]    rsp_bin,
    output logic [BW-1:0]     rsp_bcd,
    output logic              mul_start,
    output logic [N-1:0]      mul_a,
    output logic [N-1:0]      mul_b,
    input  logic              mul_finish,
    input  logic [2*N-1:0]    mul_out,
    input  logic [BW-1:0]     mul_bcd,
    output logic              busy,
    output logic              err,
    output state_t            dbg_state
);

    localparam int TMO = timeout_cycles(N);
    localparam int WDW = $clog2(TMO + 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [IW-1:0]   id_q, id_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [2*N-1:0]  bin_q, bin_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            err_q, err_d;
    logic [WDW-1:0]  wd_q, wd_d;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req       (req_valid),
        .last      (last_grant_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    // Next-state and datapath capture for the grant/load/run/respond cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        err_d        = err_q;
        wd_d         = wd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (arb_grant[k]) begin
                            a_d = req_a[k*N +: N];
                            b_d = req_b[k*N +: N];
                        end
                    end
                    id_d         = arb_idx;
                    last_grant_d = arb_idx;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wd_d    = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                wd_d = wd_q + WDW'(1);
                if (mul_finish) begin
                    bin_d   = mul_out;
                    bcd_d   = mul_bcd;
                    state_d = ST_RESP;
                end else if (wd_d == WDW'(TMO)) begin
                    // Core never finished: report a zero result and flag it.
                    err_d   = 1'b1;
                    bin_d   = '0;
                    bcd_d   = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IW'(NREQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            bin_q        <= '0;
            bcd_q        <= '0;
            err_q        <= 1'b0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            err_q        <= err_d;
            wd_q         <= wd_d;
        end
    end

    // Grants are gated by reset so the accept pulse drops the moment reset asserts.
    assign req_ready = (reset && state_q == ST_IDLE) ? arb_grant : '0;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_bin   = bin_q;
    assign rsp_bcd   = bcd_q;
    assign mul_start = (state_q == ST_RUN);
    assign mul_a     = (state_q == ST_LOAD || state_q == ST_RUN) ? a_q : '0;
    assign mul_b     = (state_q == ST_LOAD || state_q == ST_RUN) ? b_q : '0;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_scheduler.sv
// Self-checking bench for mul_scheduler with a behavioural multiplier core.
module tb_mul_scheduler;
    import mul_pkg::*;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IW   = 2;
    localparam int BW   = bcd_width(N);
    localparam int W    = IW + 2 * N + BW;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid, rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [2*N-1:0]    rsp_bin;
    logic [BW-1:0]     rsp_bcd;
    logic              mul_start, mul_finish;
    logic [N-1:0]      mul_a, mul_b;
    logic [2*N-1:0]    mul_out;
    logic [BW-1:0]     mul_bcd;
    logic              busy, err;
    state_t            dbg_state;

    always #5 clk = ~clk;

    mul_scheduler #(.N(N), .NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_bin    (rsp_bin),
        .rsp_bcd    (rsp_bcd),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_finish (mul_finish),
        .mul_out    (mul_out),
        .mul_bcd    (mul_bcd),
        .busy       (busy),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ---------------- helpers ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [BW-1:0] to_bcd(input logic [2*N-1:0] v);
        logic [BW-1:0] r;
        int unsigned   x;
        r = '0;
        x = 32'(v);
        for (int d = 0; d < BW / 4; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
        return -1;
    endfunction

    // ---------------- behavioural multiplier core ----------------
    int   core_lat   = 0;
    logic core_stuck = 1'b0;
    int   core_cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset)         core_cnt <= 0;
        else if (mul_start) core_cnt <= core_cnt + 1;
        else                core_cnt <= 0;
    end

    assign mul_finish = mul_start && !core_stuck && (core_cnt >= core_lat);
    assign mul_out    = (2*N)'(mul_a) * (2*N)'(mul_b);
    assign mul_bcd    = to_bcd(mul_out);

    // ---------------- scoreboard ----------------
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   sb_e;
    int             sb_idx;
    logic [2*N-1:0] sb_p;

    always @(negedge clk) begin
        if (reset && req_ready != '0) begin
            check("grant_onehot", 64'($onehot(req_ready)), 64'd1);
            check("grant_only_idle", 64'(busy), 64'd0);
            sb_idx = onehot_idx(req_ready);
            if (core_stuck) sb_p = '0;
            else sb_p = (2*N)'(req_a[sb_idx*N +: N]) * (2*N)'(req_b[sb_idx*N +: N]);
            exp_q.push_back({IW'(sb_idx), sb_p, to_bcd(sb_p)});
        end
        if (reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_rsp", 64'd1, 64'd0);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_rsp_id",  64'(rsp_id),  64'(sb_e[W-1 -: IW]));
                check("sb_rsp_bin", 64'(rsp_bin), 64'(sb_e[BW +: 2*N]));
                check("sb_rsp_bcd", 64'(rsp_bcd), 64'(sb_e[BW-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[k*N +: N] = a;
        req_b[k*N +: N] = b;
    endtask

    task automatic wait_grant(input int max, output int idx, output int waited);
        idx    = -1;
        waited = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            waited++;
            if (req_ready != '0) begin
                idx = onehot_idx(req_ready);
                break;
            end
        end
        if (idx < 0) check("grant_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(input int max, output int cycles);
        cycles = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            cycles++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    int g, waited, cyc, run_cnt;
    bit seen;

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b0;
        #2;
        // Reset values, with all requesters pending.
        reset     = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_bin",   64'(rsp_bin),   64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_err",       64'(err),       64'd0);
        check("rst_mul_start", 64'(mul_start), 64'd0);
        check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
        req_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single request: 12 * 13 from requester 0.
        set_op(0, 8'd12, 8'd13);
        rsp_ready = 1'b1;
        core_lat  = 3;
        req_valid = 4'b0001;
        wait_grant(20, g, waited);
        check("t1_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        set_op(0, 8'd99, 8'd99);
        @(negedge clk);
        check("t1_ready_pulse", 64'(req_ready), 64'd0);
        check("t1_load_state",  64'(dbg_state), 64'(ST_LOAD));
        check("t1_load_start",  64'(mul_start), 64'd0);
        check("t1_load_a",      64'(mul_a),     64'd12);
        check("t1_load_b",      64'(mul_b),     64'd13);
        tick();
        @(negedge clk);
        check("t1_run_start", 64'(mul_start), 64'd1);
        check("t1_run_a",     64'(mul_a),     64'd12);
        wait_rsp(50, cyc);
        check("t1_latency", 64'(2 + cyc), 64'(core_lat + 3));
        check("t1_rsp_id",  64'(rsp_id),  64'd0);
        check("t1_rsp_bin", 64'(rsp_bin), 64'd156);
        check("t1_rsp_bcd", 64'(rsp_bcd), 64'h000156);
        tick();
        @(negedge clk);
        check("t1_idle", 64'(busy), 64'd0);

        // All four valid: round-robin from a fresh reset.
        pulse_reset();
        for (int k = 0; k < NREQ; k++)
            set_op(k, N'($urandom_range(0, 255)), N'($urandom_range(0, 255)));
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(30, g, waited);
            check("t2_order", 64'(g), 64'(k % NREQ));
            if (k > 0) check("t2_gap", 64'(waited), 64'd1);
            tick();
            core_lat = $urandom_range(0, 6);
            for (int j = 0; j < NREQ; j++)
                set_op(j, N'($urandom_range(0, 255)), N'($urandom_range(0, 255)));
            wait_rsp(50, cyc);
        end
        req_valid = '0;
        tick();

        // Backpressure with max operands from requester 2.
        set_op(2, 8'd255, 8'd255);
        rsp_ready = 1'b0;
        core_lat  = 2;
        req_valid = 4'b0100;
        wait_grant(20, g, waited);
        check("t3_grant", 64'(g), 64'd2);
        tick();
        req_valid = 4'b1011;
        wait_rsp(50, cyc);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("t3_hold_valid", 64'(rsp_valid), 64'd1);
            check("t3_hold_id",    64'(rsp_id),    64'd2);
            check("t3_hold_bin",   64'(rsp_bin),   64'd65025);
            check("t3_hold_bcd",   64'(rsp_bcd),   64'h065025);
            check("t3_no_grant",   64'(req_ready), 64'd0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("t3_idle_state", 64'(dbg_state), 64'(ST_IDLE));
        check("t3_rsp_drop",   64'(rsp_valid), 64'd0);
        check("t3_next_grant", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        core_lat  = 1;
        wait_rsp(50, cyc);
        tick();

        // Stuck core: watchdog timeout.
        core_stuck = 1'b1;
        rsp_ready  = 1'b0;
        set_op(0, 8'd7, 8'd9);
        req_valid  = 4'b0001;
        wait_grant(20, g, waited);
        check("t4_grant", 64'(g), 64'd0);
        check("t4_err_before", 64'(err), 64'd0);
        tick();
        req_valid = '0;
        run_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (mul_start) run_cnt++;
        end
        check("t4_run_cycles", 64'(run_cnt), 64'(N + 4));
        check("t4_rsp_valid",  64'(rsp_valid), 64'd1);
        check("t4_err",        64'(err),     64'd1);
        check("t4_rsp_bin",    64'(rsp_bin), 64'd0);
        check("t4_rsp_bcd",    64'(rsp_bcd), 64'd0);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        tick();
        core_stuck = 1'b0;
        @(negedge clk);
        check("t4_err_sticky", 64'(err), 64'd1);
        check("t4_idle",       64'(busy), 64'd0);

        // Reset in the middle of RUN discards the operation.
        core_stuck = 1'b1;
        set_op(3, 8'd255, 8'd255);
        req_valid  = 4'b1000;
        wait_grant(20, g, waited);
        check("t5_grant", 64'(g), 64'd3);
        tick();
        req_valid = '0;
        repeat (3) @(negedge clk);
        check("t5_in_run", 64'(mul_start), 64'd1);
        #2;
        req_valid = 4'b1111;
        reset     = 1'b0;
        #1;
        check("t5_req_ready", 64'(req_ready), 64'd0);
        check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t5_rsp_id",    64'(rsp_id),    64'd0);
        check("t5_rsp_bin",   64'(rsp_bin),   64'd0);
        check("t5_rsp_bcd",   64'(rsp_bcd),   64'd0);
        check("t5_mul_start", 64'(mul_start), 64'd0);
        check("t5_mul_a",     64'(mul_a),     64'd0);
        check("t5_mul_b",     64'(mul_b),     64'd0);
        check("t5_busy",      64'(busy),      64'd0);
        check("t5_err",       64'(err),       64'd0);
        exp_q.delete();
        req_valid  = '0;
        core_stuck = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("t5_no_rsp_after", 64'(seen), 64'd0);
        tick();
        req_valid = 4'b1010;
        core_lat  = 0;
        wait_grant(20, g, waited);
        check("t5_first_grant", 64'(g), 64'd1);
        tick();
        req_valid = '0;
        wait_rsp(50, cyc);
        tick();
        tick();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #300000;
        $display("FAIL sim_timeout: got no end expected end by 300000");
        $fatal(1);
    end

endmodule
